// File: rtl/signature_compactor.sv
// Signature compactor: drives a free-running stimulus count to a design under
// observation and folds its masked observation channels into a rotating signature.
module signature_compactor #(
    parameter int STIM_W = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int NUM_CH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     continuous,
    input  logic [DATA_W-1:0]        seed,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_mask,
    output logic [STIM_W-1:0]        stimulus,
    output logic [ACC_W-1:0]         signature,
    output logic [ACC_W-1:0]         sig_hold,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               run_count
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [STIM_W-1:0]   stim_r, stim_s;
    logic [ACC_W-1:0]    sig_r, sig_s;
    logic [ACC_W-1:0]    hold_r, hold_s;
    logic [DATA_W-1:0]   seed_r, seed_s;
    logic                done_r, done_s;
    logic [7:0]          rc_r, rc_s;
    logic [DATA_W-1:0]   scr_s;
    logic [ACC_W-1:0]    next_sig_s;
    logic                full_s;

    // Seed XORed with every channel whose mask bit is set.
    function automatic logic [DATA_W-1:0] scramble(
        input logic [DATA_W-1:0]        s,
        input logic [NUM_CH*DATA_W-1:0] d,
        input logic [NUM_CH-1:0]        m
    );
        logic [DATA_W-1:0] acc;
        acc = s;
        for (int k = 0; k < NUM_CH; k++) begin
            if (m[k]) begin
                acc = acc ^ d[k*DATA_W +: DATA_W];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // One-bit left rotate of the accumulator with the low field replaced by the sum.
    function automatic logic [ACC_W-1:0] fold(
        input logic [ACC_W-1:0]  acc,
        input logic [DATA_W-1:0] scr
    );
        logic [DATA_W-1:0] add;
        add = acc[DATA_W-1:0] + scr;
        return {acc[ACC_W-2:DATA_W], add, acc[ACC_W-1]};
    endfunction

    assign scr_s      = scramble(seed_r, ch_data, ch_mask);
    assign next_sig_s = fold(sig_r, scr_s);
    assign full_s     = (stim_r == {STIM_W{1'b1}});

    // Next-state and datapath decode; every register holds unless a branch loads it.
    always_comb begin
        state_s = state_r;
        stim_s  = stim_r;
        sig_s   = sig_r;
        hold_s  = hold_r;
        seed_s  = seed_r;
        done_s  = 1'b0;
        rc_s    = rc_r;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_s = RUN;
                    stim_s  = {STIM_W{1'b0}};
                    sig_s   = {ACC_W{1'b0}};
                    seed_s  = seed;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (!full_s) begin
                    sig_s  = next_sig_s;
                    stim_s = stim_r + {{(STIM_W-1){1'b0}}, 1'b1};
                end else begin
                    // Count is full: capture without a final fold.
                    hold_s = sig_r;
                    done_s = 1'b1;
                    rc_s   = rc_r + 8'd1;
                    if (continuous) begin
                        stim_s = {STIM_W{1'b0}};
                        sig_s  = {ACC_W{1'b0}};
                        seed_s = seed;
                    end else begin
                        state_s = IDLE;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            stim_r  <= {STIM_W{1'b0}};
            sig_r   <= {ACC_W{1'b0}};
            hold_r  <= {ACC_W{1'b0}};
            seed_r  <= {DATA_W{1'b0}};
            done_r  <= 1'b0;
            rc_r    <= 8'd0;
        end else begin
            state_r <= state_s;
            stim_r  <= stim_s;
            sig_r   <= sig_s;
            hold_r  <= hold_s;
            seed_r  <= seed_s;
            done_r  <= done_s;
            rc_r    <= rc_s;
        end
    end

    assign stimulus  = stim_r;
    assign signature = sig_r;
    assign sig_hold  = hold_r;
    assign busy      = (state_r == RUN);
    assign done      = done_r;
    assign run_count = rc_r;

endmodule
